// File: rtl/branch_stage2_if.sv
// Writeback handshake between the branch resolve stage and the register file.
// The resolve stage is the master: it raises wbValid with LR/CTR data until wbAck.
interface branch_stage2_if #(
    parameter int addressWidth = 64
);
    logic                    wbValid;
    logic                    linkRegWrite;
    logic [addressWidth-1:0] linkRegVal;
    logic                    countRegWrite;
    logic [addressWidth-1:0] countRegVal;
    logic                    wbAck;

    modport master (
        output wbValid, linkRegWrite, linkRegVal, countRegWrite, countRegVal,
        input  wbAck
    );

    modport slave (
        input  wbValid, linkRegWrite, linkRegVal, countRegWrite, countRegVal,
        output wbAck
    );
endinterface

// File: rtl/branch_stage2.sv
// Branch resolve stage: evaluates CTR/CR conditions, issues the fetch redirect
// and holds an LR/CTR writeback request until the register file acknowledges it.
module branch_stage2 #(
    parameter int addressWidth = 64,
    parameter int instrBytes   = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    stall_i,
    input  logic                    enable_i,
    input  logic                    isConditional_i,
    input  logic                    isBcctr_i,
    input  logic [0:4]              BO_i,
    input  logic [5:0]              BI_i,
    input  logic [1:0]              BH_i,
    input  logic [32:63]            conditionRegVal_i,
    input  logic                    LK_i,
    input  logic                    is64Bit_i,
    input  logic [addressWidth-1:0] CIA_i,
    input  logic [addressWidth-1:0] branchOffset_i,
    input  logic [addressWidth-1:0] currentCountReg_i,
    input  logic [addressWidth-1:0] currentCountRegMinusOne_i,
    branch_stage2_if.master         wb,
    output logic                    redirectValid_o,
    output logic                    branchTaken_o,
    output logic [addressWidth-1:0] nextInstrAddr_o,
    output logic [1:0]              BH_o,
    output logic                    stall_o,
    output logic                    illegal_o
);
    typedef enum logic {IDLE, WAIT_WB} state_t;

    state_t                  state_q, state_d;
    logic                    redirect_q, redirect_d;
    logic                    taken_q, taken_d;
    logic [addressWidth-1:0] nia_q, nia_d;
    logic [1:0]              bh_q, bh_d;
    logic                    wb_valid_q, wb_valid_d;
    logic                    lr_write_q, lr_write_d;
    logic [addressWidth-1:0] lr_val_q, lr_val_d;
    logic                    ctr_write_q, ctr_write_d;
    logic [addressWidth-1:0] ctr_val_q, ctr_val_d;
    logic                    illegal_q, illegal_d;

    logic                    accept;
    logic                    ctr_dec, ctr_zero, ctr_ok, cond_ok, taken, is_illegal, ctr_write;
    logic                    cr_bit;
    logic [31:0]             cr_le;
    logic [addressWidth-1:0] fall_through, nia_raw, nia_mode, lr_mode;

    // The CTR value itself is never needed: CTR-1 carries both the zero test and the new value.
    logic unused_inputs;
    assign unused_inputs = ^{currentCountReg_i, BO_i[4]};

    always_comb begin
        accept       = enable_i & ~stall_i & (state_q == IDLE);
        cr_le        = conditionRegVal_i;
        cr_bit       = BI_i[5] & cr_le[5'd31 - BI_i[4:0]];
        ctr_dec      = ~BO_i[2];
        ctr_zero     = is64Bit_i ? (currentCountRegMinusOne_i == '0)
                                 : (currentCountRegMinusOne_i[31:0] == 32'd0);
        ctr_ok       = isBcctr_i | BO_i[2] | (ctr_zero ^ ~BO_i[3]);
        cond_ok      = BO_i[0] | (cr_bit == BO_i[1]);
        taken        = ~isConditional_i | (ctr_ok & cond_ok);
        is_illegal   = isBcctr_i & ~BO_i[2];
        ctr_write    = ctr_dec & ~isBcctr_i;
        fall_through = CIA_i + addressWidth'(instrBytes);
        nia_raw      = taken ? branchOffset_i : fall_through;
        nia_mode     = is64Bit_i ? nia_raw
                                 : {{(addressWidth-32){1'b0}}, nia_raw[31:0]};
        lr_mode      = is64Bit_i ? fall_through
                                 : {{(addressWidth-32){1'b0}}, fall_through[31:0]};
    end

    always_comb begin
        state_d     = state_q;
        redirect_d  = 1'b0;
        illegal_d   = 1'b0;
        taken_d     = taken_q;
        nia_d       = nia_q;
        bh_d        = bh_q;
        wb_valid_d  = wb_valid_q;
        lr_write_d  = lr_write_q;
        lr_val_d    = lr_val_q;
        ctr_write_d = ctr_write_q;
        ctr_val_d   = ctr_val_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bh_d = BH_i;
                    if (is_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        redirect_d = 1'b1;
                        taken_d    = taken;
                        nia_d      = nia_mode;
                        if (LK_i | ctr_write) begin
                            state_d     = WAIT_WB;
                            wb_valid_d  = 1'b1;
                            lr_write_d  = LK_i;
                            lr_val_d    = lr_mode;
                            ctr_write_d = ctr_write;
                            ctr_val_d   = currentCountRegMinusOne_i;
                        end
                    end
                end
            end
            WAIT_WB: begin
                // Ack completes regardless of stall_i; the request values stay put.
                if (wb.wbAck) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b0;
                    lr_write_d  = 1'b0;
                    ctr_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            redirect_q  <= 1'b0;
            taken_q     <= 1'b0;
            nia_q       <= '0;
            bh_q        <= '0;
            wb_valid_q  <= 1'b0;
            lr_write_q  <= 1'b0;
            lr_val_q    <= '0;
            ctr_write_q <= 1'b0;
            ctr_val_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            redirect_q  <= redirect_d;
            taken_q     <= taken_d;
            nia_q       <= nia_d;
            bh_q        <= bh_d;
            wb_valid_q  <= wb_valid_d;
            lr_write_q  <= lr_write_d;
            lr_val_q    <= lr_val_d;
            ctr_write_q <= ctr_write_d;
            ctr_val_q   <= ctr_val_d;
            illegal_q   <= illegal_d;
        end
    end

    assign redirectValid_o  = redirect_q;
    assign branchTaken_o    = taken_q;
    assign nextInstrAddr_o  = nia_q;
    assign BH_o             = bh_q;
    assign illegal_o        = illegal_q;
    assign stall_o          = (state_q == WAIT_WB);
    assign wb.wbValid       = wb_valid_q;
    assign wb.linkRegWrite  = lr_write_q;
    assign wb.linkRegVal    = lr_val_q;
    assign wb.countRegWrite = ctr_write_q;
    assign wb.countRegVal   = ctr_val_q;
endmodule

// File: tb/tb_branch_stage2.sv
// Directed bench for branch_stage2: expected outputs are queued as each step is
// driven and popped/compared one cycle later, after the clock edge.
module tb_branch_stage2;
    logic        clk = 1'b0;
    logic        srst;
    logic        stall_i, enable_i, is_cond, is_bcctr, lk, is64;
    logic [0:4]  bo;
    logic [5:0]  bi;
    logic [1:0]  bh;
    logic [32:63] cr;
    logic [63:0] cia, off, ctr, ctrm1;
    logic        redirect, taken, stall_o, illegal;
    logic [63:0] nia;
    logic [1:0]  bh_o;

    typedef struct {
        logic        redirect;
        logic        taken;
        logic [63:0] nia;
        logic [1:0]  bh;
        logic        wbv;
        logic        lrw;
        logic [63:0] lrv;
        logic        crw;
        logic [63:0] crv;
        logic        stall;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_stage2_if #(.addressWidth(64)) wb ();

    branch_stage2 #(.addressWidth(64), .instrBytes(4)) dut (
        .clock_i                   (clk),
        .reset_i                   (srst),
        .stall_i                   (stall_i),
        .enable_i                  (enable_i),
        .isConditional_i           (is_cond),
        .isBcctr_i                 (is_bcctr),
        .BO_i                      (bo),
        .BI_i                      (bi),
        .BH_i                      (bh),
        .conditionRegVal_i         (cr),
        .LK_i                      (lk),
        .is64Bit_i                 (is64),
        .CIA_i                     (cia),
        .branchOffset_i            (off),
        .currentCountReg_i         (ctr),
        .currentCountRegMinusOne_i (ctrm1),
        .wb                        (wb),
        .redirectValid_o           (redirect),
        .branchTaken_o             (taken),
        .nextInstrAddr_o           (nia),
        .BH_o                      (bh_o),
        .stall_o                   (stall_o),
        .illegal_o                 (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic t, input logic [63:0] n, input logic [1:0] h,
                        input logic v, input logic lw, input logic [63:0] lv,
                        input logic cw, input logic [63:0] cv, input logic s, input logic il);
        exp_t e;
        e.redirect = r; e.taken = t; e.nia = n; e.bh = h; e.wbv = v;
        e.lrw = lw; e.lrv = lv; e.crw = cw; e.crv = cv; e.stall = s; e.illegal = il;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty, observed nothing expected", name);
        end else begin
            e = sb.pop_front();
            cmp({name, ".redirect"}, 64'(redirect), 64'(e.redirect));
            cmp({name, ".taken"},    64'(taken),    64'(e.taken));
            cmp({name, ".nia"},      nia,           e.nia);
            cmp({name, ".bh"},       64'(bh_o),     64'(e.bh));
            cmp({name, ".wbValid"},  64'(wb.wbValid), 64'(e.wbv));
            cmp({name, ".lrWrite"},  64'(wb.linkRegWrite), 64'(e.lrw));
            cmp({name, ".ctrWrite"}, 64'(wb.countRegWrite), 64'(e.crw));
            cmp({name, ".stall"},    64'(stall_o),  64'(e.stall));
            cmp({name, ".illegal"},  64'(illegal),  64'(e.illegal));
            if (e.lrw) cmp({name, ".lrVal"},  wb.linkRegVal,  e.lrv);
            if (e.crw) cmp({name, ".ctrVal"}, wb.countRegVal, e.crv);
            $display("[TB] %s: redirect=%0b taken=%0b nia=%0h wbValid=%0b stall=%0b illegal=%0b",
                     name, redirect, taken, nia, wb.wbValid, stall_o, illegal);
        end
    endtask

    task automatic set_br(input logic c, input logic bc, input logic [0:4] o, input logic [5:0] i,
                          input logic [1:0] h, input logic l, input logic m64,
                          input logic [63:0] a, input logic [63:0] t,
                          input logic [63:0] cnt, input logic [63:0] cntm1);
        enable_i = 1'b1; is_cond = c; is_bcctr = bc; bo = o; bi = i; bh = h;
        lk = l; is64 = m64; cia = a; off = t; ctr = cnt; ctrm1 = cntm1;
    endtask

    initial begin
        srst = 1'b1; stall_i = 1'b0; enable_i = 1'b0; is_cond = 1'b0; is_bcctr = 1'b0;
        bo = '0; bi = 6'd32; bh = '0; cr = '0; lk = 1'b0; is64 = 1'b1;
        cia = '0; off = '0; ctr = '0; ctrm1 = '0; wb.wbAck = 1'b0;
        tick(); tick();
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset");
        srst = 1'b0;

        // Unconditional b with link; ack held off for three stall cycles
        set_br(0, 0, 5'b10100, 6'd32, 2'd1, 1, 1, 64'h1000, 64'h2000, 64'd5, 64'd4);
        tick(); enable_i = 1'b0;
        push(1, 1, 64'h2000, 1, 1, 1, 64'h1004, 0, 0, 1, 0);
        check("b_accept");
        tick(); push(0, 1, 64'h2000, 1, 1, 1, 64'h1004, 0, 0, 1, 0); check("b_wait1");
        tick(); push(0, 1, 64'h2000, 1, 1, 1, 64'h1004, 0, 0, 1, 0); check("b_wait2");
        wb.wbAck = 1'b1;
        tick(); wb.wbAck = 1'b0;
        push(0, 1, 64'h2000, 1, 0, 0, 0, 0, 0, 0, 0);
        check("b_ack");

        // bc decrementing CTR to zero: not taken, CTR written; ack under stall_i
        set_br(1, 0, 5'b10000, 6'd32, 2'd2, 0, 1, 64'h3000, 64'h5000, 64'd1, 64'd0);
        tick(); enable_i = 1'b0;
        push(1, 0, 64'h3004, 2, 1, 0, 0, 1, 64'd0, 1, 0);
        check("bc_ctr_accept");
        wb.wbAck = 1'b1; stall_i = 1'b1;
        tick(); wb.wbAck = 1'b0; stall_i = 1'b0;
        push(0, 0, 64'h3004, 2, 0, 0, 0, 0, 0, 0, 0);
        check("bc_ctr_ack_stalled");

        // CR-only condition, back to back, then an ack while idle
        cr = '0; cr[34] = 1'b1;
        set_br(1, 0, 5'b01100, 6'd34, 2'd3, 0, 1, 64'h400, 64'h800, 64'd7, 64'd6);
        tick();
        push(1, 1, 64'h800, 3, 0, 0, 0, 0, 0, 0, 0);
        check("bc_cr_taken");
        cr[34] = 1'b0;
        tick(); enable_i = 1'b0; wb.wbAck = 1'b1;
        push(1, 0, 64'h404, 3, 0, 0, 0, 0, 0, 0, 0);
        check("bc_cr_not_taken");
        tick(); wb.wbAck = 1'b0;
        push(0, 0, 64'h404, 3, 0, 0, 0, 0, 0, 0, 0);
        check("idle_ack_ignored");

        // 32-bit mode: only the low word of CTR-1 counts, NIA upper word cleared
        set_br(1, 0, 5'b10000, 6'd32, 2'd0, 0, 0, 64'hFFFF_FFFC, 64'h9000, 64'h1_0000_0001, 64'h1_0000_0000);
        tick(); enable_i = 1'b0;
        push(1, 0, 64'h0, 0, 1, 0, 0, 1, 64'h1_0000_0000, 1, 0);
        check("mode32_accept");
        wb.wbAck = 1'b1;
        tick(); wb.wbAck = 1'b0;
        push(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mode32_ack");

        // bcctr: decrementing form is illegal, then a legal linking form
        set_br(1, 1, 5'b00000, 6'd32, 2'd1, 0, 1, 64'h600, 64'h900, 64'd3, 64'd2);
        tick();
        push(0, 0, 64'h0, 1, 0, 0, 0, 0, 0, 0, 1);
        check("bcctr_illegal");
        set_br(1, 1, 5'b10100, 6'd32, 2'd2, 1, 1, 64'h700, 64'hA00, 64'd3, 64'd2);
        tick(); enable_i = 1'b0;
        push(1, 1, 64'hA00, 2, 1, 1, 64'h704, 0, 0, 1, 0);
        check("bcctr_link");
        wb.wbAck = 1'b1;
        tick(); wb.wbAck = 1'b0;
        push(0, 1, 64'hA00, 2, 0, 0, 0, 0, 0, 0, 0);
        check("bcctr_ack");

        // Second branch arrives together with the ack: accepted one cycle later
        set_br(0, 0, 5'b10100, 6'd32, 2'd0, 1, 1, 64'h100, 64'h200, 64'd0, 64'd0);
        tick();
        push(1, 1, 64'h200, 0, 1, 1, 64'h104, 0, 0, 1, 0);
        check("b2b_first");
        set_br(1, 0, 5'b10100, 6'd32, 2'd3, 0, 1, 64'h300, 64'h600, 64'd9, 64'd8);
        wb.wbAck = 1'b1;
        tick(); wb.wbAck = 1'b0;
        push(0, 1, 64'h200, 0, 0, 0, 0, 0, 0, 0, 0);
        check("b2b_ack_no_accept");
        tick(); enable_i = 1'b0;
        push(1, 1, 64'h600, 3, 0, 0, 0, 0, 0, 0, 0);
        check("b2b_second");

        // Reset while a writeback is outstanding drops it
        set_br(0, 0, 5'b10100, 6'd32, 2'd1, 1, 1, 64'h900, 64'hB00, 64'd0, 64'd0);
        tick(); enable_i = 1'b0;
        push(1, 1, 64'hB00, 1, 1, 1, 64'h904, 0, 0, 1, 0);
        check("rst_pending");
        srst = 1'b1;
        tick(); srst = 1'b0;
        push(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_in_wait");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
